// File: rtl/alu_param_if.sv
// ALU front-panel bus: operand loads, launch handshake,
// LED mirrors, flags and the multiplexed 7-segment display.
interface alu_param_if #(
  parameter int WIDTH = 8
);
  logic [3:0]       select;
  logic [WIDTH-1:0] numbers;
  logic             load_a;
  logic             load_b;
  logic             start;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ledA;
  logic [WIDTH-1:0] ledB;
  logic [WIDTH-1:0] ledY;
  logic             flag_c;
  logic             flag_z;
  logic             flag_v;
  logic [6:0]       display_segs;
  logic [3:0]       display_anodes;

  modport master (
    output select, numbers, load_a, load_b, start,
    input  busy, done, ledA, ledB, ledY,
    input  flag_c, flag_z, flag_v,
    input  display_segs, display_anodes
  );

  modport slave (
    input  select, numbers, load_a, load_b, start,
    output busy, done, ledA, ledB, ledY,
    output flag_c, flag_z, flag_v,
    output display_segs, display_anodes
  );
endinterface

// File: rtl/alu_param.sv
// Parameterised ALU with bit-serial shifter, status flags
// and a scanned 4-digit 7-segment status display.
module alu_param #(
  parameter int WIDTH       = 8,
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  alu_param_if.slave bus
);
  localparam int LW = $clog2(WIDTH);
  localparam int M  = WIDTH - 1;
  localparam logic [31:0] DIV_MAX = 32'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    IDLE, EXEC, SHIFT, DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a, r_b, r_y;
  logic             r_c, r_z, r_v;
  logic [3:0]       r_op;
  logic [LW-1:0]    r_cnt;
  logic [31:0]      r_div;
  logic [1:0]       r_dig;

  logic             w_is_shift;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_c, w_v;
  logic [WIDTH-1:0] w_sh;
  logic             w_sc;
  logic [3:0]       w_digit;

  assign w_is_shift = (bus.select == 4'b0010) ||
                      (bus.select == 4'b0011) ||
                      (bus.select == 4'b1111);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.start) w_next = w_is_shift ? SHIFT : EXEC;
      EXEC:    w_next = DONE;
      SHIFT:   if (r_cnt == '0) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_sum  = {1'b0, r_a} + {1'b0, r_b};
    w_diff = r_a - r_b;
    w_res  = r_y;
    w_c    = 1'b0;
    w_v    = 1'b0;
    case (r_op)
      4'b0000: begin
        w_res = w_sum[M:0];
        w_c   = w_sum[WIDTH];
        w_v   = (r_a[M] == r_b[M]) && (w_sum[M] != r_a[M]);
      end
      4'b0001: begin
        w_res = w_diff;
        w_c   = r_a < r_b;
        w_v   = (r_a[M] != r_b[M]) && (w_diff[M] != r_a[M]);
      end
      4'b0100: w_res = {WIDTH{r_a == r_b}};
      4'b0101: w_res = r_a & r_b;
      4'b0110: w_res = r_a | r_b;
      4'b0111: w_res = r_a ^ r_b;
      4'b1000: w_res = ~(r_a & r_b);
      4'b1001: w_res = ~(r_a | r_b);
      4'b1010: w_res = ~(r_a ^ r_b);
      4'b1011: w_res = ~r_a;
      4'b1100: w_res = -r_a;
      4'b1101: w_res = r_a;
      default: w_res = r_y;
    endcase
  end

  // one bit per SHIFT cycle; rotate never reports a carry
  always_comb begin
    w_sh = r_y;
    w_sc = 1'b0;
    case (r_op)
      4'b0010: begin
        w_sh = {r_y[M-1:0], 1'b0};
        w_sc = r_y[M];
      end
      4'b0011: begin
        w_sh = {1'b0, r_y[M:1]};
        w_sc = r_y[0];
      end
      4'b1111: w_sh = {r_y[M-1:0], r_y[M]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_y   <= '0;
      r_c   <= 1'b0;
      r_z   <= 1'b0;
      r_v   <= 1'b0;
      r_op  <= '0;
      r_cnt <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_op <= bus.select;
            if (w_is_shift) begin
              r_y   <= r_a;
              r_cnt <= r_b[LW-1:0];
              r_c   <= 1'b0;
              r_v   <= 1'b0;
              r_z   <= (r_a == '0);
            end
          end else begin
            if (bus.load_a) r_a <= bus.numbers;
            if (bus.load_b) r_b <= bus.numbers;
          end
        end
        EXEC: begin
          if (r_op == 4'b1110) begin
            r_a <= r_b;
            r_b <= r_a;
          end else begin
            r_y <= w_res;
            r_c <= w_c;
            r_v <= w_v;
            r_z <= (w_res == '0);
          end
        end
        SHIFT: begin
          if (r_cnt != '0) begin
            r_y   <= w_sh;
            r_c   <= w_sc;
            r_z   <= (w_sh == '0);
            r_cnt <= r_cnt - LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div <= '0;
      r_dig <= '0;
    end else if (r_div == DIV_MAX) begin
      r_div <= '0;
      r_dig <= r_dig + 2'd1;
    end else begin
      r_div <= r_div + 32'd1;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  always_comb begin
    w_digit = bus.select;
    unique case (r_dig)
      2'd0:    w_digit = bus.select;
      2'd1:    w_digit = {1'b0, r_v, r_c, r_z};
      2'd2:    w_digit = r_y[3:0];
      default: w_digit = r_y[7:4];
    endcase
  end

  assign bus.display_anodes = ~(4'b0001 << r_dig);
  assign bus.display_segs   = seg7(w_digit);

  assign bus.busy   = (r_state == EXEC) || (r_state == SHIFT);
  assign bus.done   = (r_state == DONE);
  assign bus.ledA   = r_a;
  assign bus.ledB   = r_b;
  assign bus.ledY   = r_y;
  assign bus.flag_c = r_c;
  assign bus.flag_z = r_z;
  assign bus.flag_v = r_v;
endmodule

// File: tb/tb_alu_param.sv
// Randomised and directed bench for alu_param against an
// arithmetic reference model (WIDTH=8, REFRESH_DIV=4).
module tb_alu_param;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  int   m_a, m_b, m_y;
  logic m_c, m_z, m_v;

  logic [6:0] seg_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  alu_param_if #(.WIDTH(8)) bus ();

  alu_param #(
    .WIDTH(8),
    .REFRESH_DIV(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, want finish");
    $fatal(1, "watchdog");
  end

  function automatic int sgn(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  task automatic model_reset();
    m_a = 0; m_b = 0; m_y = 0;
    m_c = 0; m_z = 0; m_v = 0;
  endtask

  // expected result from plain integer arithmetic; bc = busy cycles
  task automatic model_op(input int op, output int bc);
    int a, b, n, s;
    a = m_a; b = m_b; n = b % 8;
    bc = 1;
    m_c = 0; m_v = 0;
    case (op)
      0: begin
        s = a + b; m_y = s % 256; m_c = (s > 255);
        s = sgn(a) + sgn(b); m_v = (s > 127) || (s < -128);
      end
      1: begin
        m_y = (a - b + 256) % 256; m_c = (a < b);
        s = sgn(a) - sgn(b); m_v = (s > 127) || (s < -128);
      end
      2: begin
        bc = n + 1; m_y = (a << n) % 256;
        m_c = (n == 0) ? 1'b0 : 1'(((a >> (8 - n)) & 1));
      end
      3: begin
        bc = n + 1; m_y = a >> n;
        m_c = (n == 0) ? 1'b0 : 1'(((a >> (n - 1)) & 1));
      end
      15: begin
        bc = n + 1; m_y = ((a << n) | (a >> (8 - n))) % 256;
      end
      4:  m_y = (a == b) ? 255 : 0;
      5:  m_y = a & b;
      6:  m_y = a | b;
      7:  m_y = a ^ b;
      8:  m_y = 255 - (a & b);
      9:  m_y = 255 - (a | b);
      10: m_y = 255 - (a ^ b);
      11: m_y = 255 - a;
      12: m_y = (256 - a) % 256;
      13: m_y = a;
      default: ;
    endcase
    if (op != 14) m_z = (m_y == 0);
    else begin
      m_a = b; m_b = a;
    end
  endtask

  task automatic load_ab(input int a, input int b);
    @(negedge clk);
    bus.numbers = 8'(a); bus.load_a = 1;
    @(negedge clk);
    bus.load_a = 0; bus.numbers = 8'(b); bus.load_b = 1;
    @(negedge clk);
    bus.load_b = 0; bus.numbers = 8'($urandom);
    m_a = a; m_b = b;
    n_checks++;
    if (bus.ledA !== 8'(m_a) || bus.ledB !== 8'(m_b)) begin
      n_fail++;
      $display("FAIL load: A=%h B=%h want A=%h B=%h",
               bus.ledA, bus.ledB, 8'(m_a), 8'(m_b));
    end
  endtask

  // launches op with junk loads alongside start and junk
  // start/loads held through busy: all must be ignored
  task automatic run_op(input int op, input string nm);
    int bc;
    model_op(op, bc);
    @(negedge clk);
    bus.start = 1; bus.select = 4'(op);
    bus.load_a = 1; bus.load_b = 1;
    bus.numbers = 8'($urandom);
    @(negedge clk);
    for (int k = 0; k < bc; k++) begin
      n_checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s busy k=%0d: busy=%b done=%b want 1 0",
                 nm, k, bus.busy, bus.done);
      end
      bus.select = 4'($urandom); bus.numbers = 8'($urandom);
      @(negedge clk);
    end
    n_checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done: done=%b busy=%b want 1 0",
               nm, bus.done, bus.busy);
    end
    n_checks++;
    if (bus.ledY !== 8'(m_y) || bus.flag_c !== m_c ||
        bus.flag_z !== m_z || bus.flag_v !== m_v) begin
      n_fail++;
      $display("FAIL %s result: Y=%h c=%b z=%b v=%b want %h %b %b %b",
               nm, bus.ledY, bus.flag_c, bus.flag_z, bus.flag_v,
               8'(m_y), m_c, m_z, m_v);
    end
    n_checks++;
    if (bus.ledA !== 8'(m_a) || bus.ledB !== 8'(m_b)) begin
      n_fail++;
      $display("FAIL %s regs: A=%h B=%h want %h %h",
               nm, bus.ledA, bus.ledB, 8'(m_a), 8'(m_b));
    end
    @(negedge clk);
    bus.start = 0; bus.load_a = 0; bus.load_b = 0;
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s pulse: done=%b busy=%b want 0 0",
               nm, bus.done, bus.busy);
    end
  endtask

  task automatic test_reset();
    bus.select = 0; bus.numbers = 0; bus.start = 0;
    bus.load_a = 0; bus.load_b = 0;
    model_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.ledA !== 0 || bus.ledB !== 0 || bus.ledY !== 0 ||
        bus.flag_c !== 0 || bus.flag_z !== 0 || bus.flag_v !== 0 ||
        bus.busy !== 0 || bus.done !== 0) begin
      n_fail++;
      $display("FAIL reset state: A=%h B=%h Y=%h cz v=%b%b%b bd=%b%b",
               bus.ledA, bus.ledB, bus.ledY, bus.flag_c, bus.flag_z,
               bus.flag_v, bus.busy, bus.done);
    end
    n_checks++;
    if (bus.display_anodes !== 4'b1110 ||
        bus.display_segs !== 7'b1111110) begin
      n_fail++;
      $display("FAIL reset display: an=%b seg=%b want 1110 1111110",
               bus.display_anodes, bus.display_segs);
    end
    reset = 1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.display_anodes !== ((k < 4) ? 4'b1110 : 4'b1101)) begin
        n_fail++;
        $display("FAIL scan start k=%0d: an=%b", k, bus.display_anodes);
      end
    end
  endtask

  task automatic test_directed();
    load_ab(8'h7F, 8'h01); run_op(0, "add_ovf");
    load_ab(8'h03, 8'h05); run_op(1, "sub_borrow");
    load_ab(8'h81, 8'h03); run_op(2, "shl3");
    load_ab(8'h81, 8'h01); run_op(15, "rol1");
    load_ab(8'h81, 8'h02); run_op(3, "shr2");
    load_ab(8'h80, 8'h08); run_op(2, "shl0");
    load_ab(8'h12, 8'h34); run_op(14, "swap");
    load_ab(8'h00, 8'h05); run_op(12, "neg0");
  endtask

  task automatic test_both_loads();
    int v;
    v = $urandom_range(0, 255);
    @(negedge clk);
    bus.numbers = 8'(v); bus.load_a = 1; bus.load_b = 1;
    @(negedge clk);
    bus.load_a = 0; bus.load_b = 0;
    m_a = v; m_b = v;
    run_op(4, "eq_both");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      load_ab($urandom_range(0, 255), $urandom_range(0, 255));
      run_op($urandom_range(0, 15), "rand");
    end
  endtask

  task automatic test_display();
    logic [3:0] cur, d;
    int run;
    logic found;
    load_ab(8'h5A, 8'h00);
    run_op(13, "pass_a");
    @(negedge clk);
    bus.select = 4'd3;
    cur = bus.display_anodes;
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (bus.display_anodes !== cur) found = 1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL scan stuck: an=%b", bus.display_anodes);
    end
    cur = bus.display_anodes;
    run = 1;
    for (int i = 0; i < 17; i++) begin
      case (cur)
        4'b1110: d = 4'd3;
        4'b1101: d = {1'b0, m_v, m_c, m_z};
        4'b1011: d = 4'(m_y % 16);
        default: d = 4'(m_y / 16);
      endcase
      n_checks++;
      if (bus.display_segs !== seg_tab[d]) begin
        n_fail++;
        $display("FAIL segs an=%b: seg=%b want %b",
                 cur, bus.display_segs, seg_tab[d]);
      end
      @(negedge clk);
      if (bus.display_anodes === cur) run++;
      else begin
        n_checks++;
        if (run != 4 || bus.display_anodes !== {cur[2:0], cur[3]}) begin
          n_fail++;
          $display("FAIL scan step: %b after %b run=%0d want %b run=4",
                   bus.display_anodes, cur, run, {cur[2:0], cur[3]});
        end
        cur = bus.display_anodes;
        run = 1;
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    int pulses;
    load_ab(8'h81, 8'h07);
    @(negedge clk);
    bus.start = 1; bus.select = 4'd2;
    @(negedge clk);
    bus.start = 0;
    @(negedge clk);
    #2 reset = 0;
    model_reset();
    #1;
    n_checks++;
    if (bus.ledA !== 0 || bus.ledB !== 0 || bus.ledY !== 0 ||
        bus.flag_c !== 0 || bus.flag_z !== 0 || bus.flag_v !== 0 ||
        bus.busy !== 0 || bus.done !== 0 ||
        bus.display_anodes !== 4'b1110) begin
      n_fail++;
      $display("FAIL async reset: A=%h B=%h Y=%h bd=%b%b an=%b",
               bus.ledA, bus.ledB, bus.ledY, bus.busy, bus.done,
               bus.display_anodes);
    end
    repeat (2) @(negedge clk);
    reset = 1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) pulses++;
    end
    n_checks++;
    if (pulses != 0 || bus.ledY !== 0) begin
      n_fail++;
      $display("FAIL abort: done/busy cycles=%0d Y=%h want 0 00",
               pulses, bus.ledY);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_both_loads();
    test_back_to_back();
    test_display();
    test_reset_mid_shift();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
